// File: rtl/prog_mem_responder_if.sv
// ---------------------------------------------------------------------------
// prog_mem_responder_if
//   Bundles the core-facing read bus and the byte-stream load port of the
//   program/data memory responder.
//
//   Read side : addr_in (core -> memory), data_out (memory -> core, registered)
//   Load side : load_start, load_valid, load_last, load_data (loader -> memory)
//               load_ready, load_done (memory -> loader)
//   Status    : serving, load_count (memory -> observer)
//
//   Modports
//     slave  : the memory responder itself
//     master : the core / loader / testbench driving it
// ---------------------------------------------------------------------------
interface prog_mem_responder_if #(
    parameter int DATA_W    = 8,
    parameter int ADDR_IN_W = 8,
    parameter int ADDR_W    = 4
);
    logic [ADDR_IN_W-1:0] addr_in;
    logic [DATA_W-1:0]    data_out;
    logic                 load_start;
    logic                 load_valid;
    logic                 load_last;
    logic [DATA_W-1:0]    load_data;
    logic                 load_ready;
    logic                 load_done;
    logic                 serving;
    logic [ADDR_W:0]      load_count;

    modport slave (
        input  addr_in, load_start, load_valid, load_last, load_data,
        output data_out, load_ready, load_done, serving, load_count
    );

    modport master (
        output addr_in, load_start, load_valid, load_last, load_data,
        input  data_out, load_ready, load_done, serving, load_count
    );
endinterface

// File: rtl/prog_mem_responder.sv
// ---------------------------------------------------------------------------
// prog_mem_responder
//   Small byte-wide program/data memory that sits beside the core. The core
//   presents an address every cycle and gets the addressed byte back one cycle
//   later. Contents are filled from a valid/ready byte stream that always
//   starts at entry 0 and auto-increments.
//
//   Ports
//     clk    : clock, all state changes on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : prog_mem_responder_if.slave (read bus, load port, status)
//
//   States: EMPTY (nothing loaded) -> LOAD (accepting bytes) -> SERVE
//   (answering reads), and SERVE -> LOAD again on a new load_start.
//   Every output comes straight from a register, so there is no
//   combinational path from any input to any output.
// ---------------------------------------------------------------------------
module prog_mem_responder #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_IN_W = 8,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] FILL_BYTE = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prog_mem_responder_if.slave  bus
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        SERVE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [ADDR_W:0]       loadCount_q, loadCount_d;
    logic                  loadDone_q, loadDone_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic                  beat;
    logic                  finalBeat;
    logic [31:0]           addrWide;
    logic                  addrInRange;
    logic [DATA_W-1:0]     rdByte;

    // A byte is taken only while in LOAD, where load_ready is high. The stream
    // ends either on an explicit last marker or when the top entry is written,
    // so the write pointer never has to wrap.
    always_comb begin
        beat        = (state_q == LOAD) && bus.load_valid;
        finalBeat   = beat && (bus.load_last || (wrPtr_q == LAST_IDX));
        addrWide    = 32'(bus.addr_in);
        addrInRange = addrWide < 32'(DEPTH);
        rdByte      = mem_q[bus.addr_in[ADDR_W-1:0]];
    end

    // Next-state logic. load_start restarts a load from EMPTY or SERVE but is
    // ignored mid-load. The read data register only follows the memory while
    // staying in SERVE; on the cycle that enters SERVE it still shows the fill
    // byte, and on the cycle load_start leaves SERVE it drops back to fill.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        loadCount_d = loadCount_q;
        loadDone_d  = 1'b0;
        data_d      = FILL_BYTE;

        case (state_q)
            EMPTY: begin
                if (bus.load_start) begin
                    state_d     = LOAD;
                    wrPtr_d     = '0;
                    loadCount_d = '0;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (wrPtr_q != LAST_IDX) begin
                        wrPtr_d = wrPtr_q + 1'b1;
                    end
                    if (loadCount_q != COUNT_MAX) begin
                        loadCount_d = loadCount_q + 1'b1;
                    end
                end
                if (finalBeat) begin
                    state_d    = SERVE;
                    loadDone_d = 1'b1;
                end
            end
            SERVE: begin
                if (bus.load_start) begin
                    state_d     = LOAD;
                    wrPtr_d     = '0;
                    loadCount_d = '0;
                end else begin
                    data_d = addrInRange ? rdByte : FILL_BYTE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            wrPtr_q     <= '0;
            loadCount_q <= '0;
            loadDone_q  <= 1'b0;
            data_q      <= FILL_BYTE;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            loadCount_q <= loadCount_d;
            loadDone_q  <= loadDone_d;
            data_q      <= data_d;
        end
    end

    // Storage array. Reset clears every entry so an interrupted load leaves no
    // stale bytes behind; otherwise entries not touched by a load keep their
    // previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (beat) begin
            mem_q[wrPtr_q] <= bus.load_data;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.load_ready = (state_q == LOAD);
    assign bus.load_done  = loadDone_q;
    assign bus.serving    = (state_q == SERVE);
    assign bus.load_count = loadCount_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_responder
//   Directed self-checking bench for prog_mem_responder. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_prog_mem_responder;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    prog_mem_responder_if #(.DATA_W(8), .ADDR_IN_W(8), .ADDR_W(4)) bus ();

    prog_mem_responder #(
        .DATA_W(8), .ADDR_IN_W(8), .ADDR_W(4), .FILL_BYTE(8'h00)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = 8'h00;
    endtask

    task automatic pulseStart();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        bus.addr_in = 8'h00;
        rst_n = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL reset_data got %h exp 00", bus.data_out); end
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("[TB] FAIL reset_ready got %b exp 0", bus.load_ready); end
        tests++; if (bus.serving !== 1'b0) begin failed++; $display("[TB] FAIL reset_serving got %b exp 0", bus.serving); end
        tests++; if (bus.load_done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done got %b exp 0", bus.load_done); end
        tests++; if (bus.load_count !== 5'd0) begin failed++; $display("[TB] FAIL reset_count got %0d exp 0", bus.load_count); end
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("[TB] FAIL empty_ready got %b exp 0", bus.load_ready); end
    endtask

    task automatic test_short_load();
        pulseStart();
        tests++; if (bus.load_ready !== 1'b1) begin failed++; $display("[TB] FAIL load_ready got %b exp 1", bus.load_ready); end
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'hA0 + 8'(i);
            bus.load_last  = (i == 4);
            tick();
        end
        idleInputs();
        tests++; if (bus.load_done !== 1'b1) begin failed++; $display("[TB] FAIL short_done got %b exp 1", bus.load_done); end
        tests++; if (bus.load_count !== 5'd5) begin failed++; $display("[TB] FAIL short_count got %0d exp 5", bus.load_count); end
        tests++; if (bus.serving !== 1'b1) begin failed++; $display("[TB] FAIL short_serving got %b exp 1", bus.serving); end
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("[TB] FAIL short_ready_low got %b exp 0", bus.load_ready); end
        tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL short_entry_fill got %h exp 00", bus.data_out); end
        for (int i = 0; i < 5; i++) begin
            bus.addr_in = 8'(i);
            tick();
            tests++; if (bus.data_out !== 8'hA0 + 8'(i)) begin failed++; $display("[TB] FAIL short_read[%0d] got %h exp %h", i, bus.data_out, 8'hA0 + 8'(i)); end
            if (i == 0) begin
                tests++; if (bus.load_done !== 1'b0) begin failed++; $display("[TB] FAIL short_done_pulse got %b exp 0", bus.load_done); end
            end
        end
    endtask

    task automatic test_full_load();
        pulseStart();
        tests++; if (bus.load_count !== 5'd0) begin failed++; $display("[TB] FAIL full_count_clr got %0d exp 0", bus.load_count); end
        tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL full_load_fill got %h exp 00", bus.data_out); end
        for (int i = 0; i < 16; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(i);
            tick();
            if (i == 14) begin
                tests++; if (bus.serving !== 1'b0) begin failed++; $display("[TB] FAIL full_early_serve got %b exp 0", bus.serving); end
            end
        end
        idleInputs();
        tests++; if (bus.serving !== 1'b1) begin failed++; $display("[TB] FAIL full_serving got %b exp 1", bus.serving); end
        tests++; if (bus.load_count !== 5'd16) begin failed++; $display("[TB] FAIL full_count got %0d exp 16", bus.load_count); end
        tests++; if (bus.load_done !== 1'b1) begin failed++; $display("[TB] FAIL full_done got %b exp 1", bus.load_done); end
        bus.addr_in = 8'h0F; tick();
        tests++; if (bus.data_out !== 8'h0F) begin failed++; $display("[TB] FAIL full_read_0F got %h exp 0F", bus.data_out); end
        bus.addr_in = 8'h10; tick();
        tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL full_read_10 got %h exp 00", bus.data_out); end
        bus.addr_in = 8'h07; tick();
        tests++; if (bus.data_out !== 8'h07) begin failed++; $display("[TB] FAIL full_read_07 got %h exp 07", bus.data_out); end
        bus.addr_in = 8'hFF; tick();
        tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL full_read_FF got %h exp 00", bus.data_out); end
    endtask

    task automatic test_backpressure();
        logic [9:0] validPat;
        logic [7:0] expBytes [6];
        validPat = 10'b11_0100_1101;
        expBytes[0] = 8'hB0; expBytes[1] = 8'hB2; expBytes[2] = 8'hB3;
        expBytes[3] = 8'hB6; expBytes[4] = 8'hB8; expBytes[5] = 8'hB9;
        pulseStart();
        for (int c = 0; c < 10; c++) begin
            bus.load_valid = validPat[c];
            bus.load_data  = 8'hB0 + 8'(c);
            bus.load_last  = (c == 1) || (c == 9);
            tick();
            if (c == 1) begin
                tests++; if (bus.serving !== 1'b0) begin failed++; $display("[TB] FAIL bp_last_no_valid got %b exp 0", bus.serving); end
                tests++; if (bus.load_count !== 5'd1) begin failed++; $display("[TB] FAIL bp_count_mid got %0d exp 1", bus.load_count); end
            end
        end
        idleInputs();
        tests++; if (bus.load_count !== 5'd6) begin failed++; $display("[TB] FAIL bp_count got %0d exp 6", bus.load_count); end
        tests++; if (bus.serving !== 1'b1) begin failed++; $display("[TB] FAIL bp_serving got %b exp 1", bus.serving); end
        for (int i = 0; i < 6; i++) begin
            bus.addr_in = 8'(i);
            tick();
            tests++; if (bus.data_out !== expBytes[i]) begin failed++; $display("[TB] FAIL bp_read[%0d] got %h exp %h", i, bus.data_out, expBytes[i]); end
        end
        bus.addr_in = 8'h06; tick();
        tests++; if (bus.data_out !== 8'h06) begin failed++; $display("[TB] FAIL bp_retain_06 got %h exp 06", bus.data_out); end
    endtask

    task automatic test_reload();
        bus.addr_in = 8'h01;
        pulseStart();
        tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL reload_fill got %h exp 00", bus.data_out); end
        tests++; if (bus.serving !== 1'b0) begin failed++; $display("[TB] FAIL reload_serving got %b exp 0", bus.serving); end
        bus.load_valid = 1'b1; bus.load_data = 8'h55; tick();
        bus.load_start = 1'b1; bus.load_valid = 1'b0; tick();
        bus.load_start = 1'b0;
        tests++; if (bus.load_count !== 5'd1) begin failed++; $display("[TB] FAIL reload_start_ignored got %0d exp 1", bus.load_count); end
        bus.load_valid = 1'b1; bus.load_data = 8'h66; bus.load_last = 1'b1; tick();
        idleInputs();
        tests++; if (bus.load_count !== 5'd2) begin failed++; $display("[TB] FAIL reload_count got %0d exp 2", bus.load_count); end
        bus.addr_in = 8'h00; tick();
        tests++; if (bus.data_out !== 8'h55) begin failed++; $display("[TB] FAIL reload_read0 got %h exp 55", bus.data_out); end
        bus.addr_in = 8'h01; tick();
        tests++; if (bus.data_out !== 8'h66) begin failed++; $display("[TB] FAIL reload_read1 got %h exp 66", bus.data_out); end
        bus.addr_in = 8'h02; tick();
        tests++; if (bus.data_out !== 8'hB3) begin failed++; $display("[TB] FAIL reload_read2 got %h exp B3", bus.data_out); end
        bus.addr_in = 8'h05; tick();
        tests++; if (bus.data_out !== 8'hB9) begin failed++; $display("[TB] FAIL reload_read5 got %h exp B9", bus.data_out); end
        bus.addr_in = 8'h0E; tick();
        tests++; if (bus.data_out !== 8'h0E) begin failed++; $display("[TB] FAIL reload_read14 got %h exp 0E", bus.data_out); end
    endtask

    task automatic test_reset_mid_load();
        pulseStart();
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'hC0 + 8'(i);
            tick();
        end
        idleInputs();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.load_count !== 5'd0) begin failed++; $display("[TB] FAIL midrst_count got %0d exp 0", bus.load_count); end
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("[TB] FAIL midrst_ready got %b exp 0", bus.load_ready); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addr_in = 8'(i);
            tick();
            tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL midrst_read[%0d] got %h exp 00", i, bus.data_out); end
        end
        pulseStart();
        bus.load_valid = 1'b1; bus.load_data = 8'h77; bus.load_last = 1'b1; tick();
        idleInputs();
        bus.addr_in = 8'h01; tick();
        tests++; if (bus.data_out !== 8'h00) begin failed++; $display("[TB] FAIL midrst_mem_clr got %h exp 00", bus.data_out); end
        bus.addr_in = 8'h00; tick();
        tests++; if (bus.data_out !== 8'h77) begin failed++; $display("[TB] FAIL midrst_newload got %h exp 77", bus.data_out); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b1;
        test_reset();
        test_short_load();
        test_full_load();
        test_backpressure();
        test_reload();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
